// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns pc and the status register, resolves jumps in DECODE.
// Optional return-address stack: define FETCH_SEQUENCER_CALL_STACK_EN.
module fetch_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic              is_jump,
  input  logic              is_halt,
  input  logic [1:0]        jump_op,
  input  logic [ADDR_W-1:0] jump_target,
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
  input  logic              is_call,
  input  logic              is_ret,
  output logic              stack_err,
`endif
  output logic              exec_en,
  input  logic              exec_done,
  input  logic              status_we,
  input  logic [2:0]        alu_status,
  output logic [2:0]        status,
  output logic [ADDR_W-1:0] pc,
  output logic              jump_taken,
  output logic              halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n, ir_target;
  logic [2:0]        status_q, status_n;
  logic              taken_q, taken_n;
  logic              ir_jump, ir_halt, latch_ir, cond;
  logic [1:0]        ir_op;

`ifdef FETCH_SEQUENCER_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack_q;
  logic [SP_W-1:0]  sp_q;
  logic [IDX_W-1:0] push_idx, top_idx;
  logic             ir_call, ir_ret, err_q, push, pop, set_err, clr;
  logic             full, empty;

  assign full      = (sp_q == SP_W'(STACK_DEPTH));
  assign empty     = (sp_q == '0);
  assign push_idx  = IDX_W'(sp_q);
  assign top_idx   = IDX_W'(sp_q - SP_W'(1));
  assign stack_err = err_q;
`endif

  assign instr_req  = (state == FETCH);
  assign exec_en    = (state == EXECUTE);
  assign halted     = (state == HALT);
  assign instr_addr = pc_q;
  assign pc         = pc_q;
  assign status     = status_q;
  assign jump_taken = taken_q;

  always_comb begin
    unique case (ir_op)
      2'b00:   cond = 1'b1;
      2'b01:   cond = status_q[0];
      2'b10:   cond = status_q[1];
      default: cond = status_q[2];
    endcase
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc_q;
    status_n = status_q;
    taken_n  = 1'b0;
    latch_ir = 1'b0;
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    set_err = 1'b0;
    clr     = 1'b0;
`endif
    unique case (state)
      IDLE: if (start) begin
        state_n = FETCH;
        pc_n    = RESET_PC;
      end
      FETCH: if (instr_ack) begin
        state_n  = DECODE;
        latch_ir = 1'b1;
      end
      DECODE: begin
        if (ir_halt) state_n = HALT;
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
        else if (ir_call) begin
          if (full) begin
            set_err = 1'b1;
            state_n = HALT;
          end else begin
            push    = 1'b1;
            pc_n    = ir_target;
            taken_n = 1'b1;
            state_n = FETCH;
          end
        end else if (ir_ret) begin
          if (empty) begin
            set_err = 1'b1;
            state_n = HALT;
          end else begin
            pop     = 1'b1;
            pc_n    = stack_q[top_idx];
            taken_n = 1'b1;
            state_n = FETCH;
          end
        end
`endif
        else if (ir_jump) begin
          state_n = FETCH;
          if (cond) begin
            pc_n    = ir_target;
            taken_n = 1'b1;
          end else begin
            pc_n = pc_q + ADDR_W'(1);
          end
        end else state_n = EXECUTE;
      end
      EXECUTE: if (exec_done) begin
        state_n = FETCH;
        pc_n    = pc_q + ADDR_W'(1);
        if (status_we) status_n = alu_status;
      end
      HALT: if (start) begin
        state_n  = FETCH;
        pc_n     = RESET_PC;
        status_n = '0;
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
        clr = 1'b1;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      status_q  <= '0;
      taken_q   <= 1'b0;
      ir_jump   <= 1'b0;
      ir_halt   <= 1'b0;
      ir_op     <= '0;
      ir_target <= '0;
    end else begin
      state    <= state_n;
      pc_q     <= pc_n;
      status_q <= status_n;
      taken_q  <= taken_n;
      if (latch_ir) begin
        ir_jump   <= is_jump;
        ir_halt   <= is_halt;
        ir_op     <= jump_op;
        ir_target <= jump_target;
      end
    end
  end

`ifdef FETCH_SEQUENCER_CALL_STACK_EN
  // Return address is pc+1 of the call; an overflowing/underflowing op leaves pc alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_q <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      ir_call <= 1'b0;
      ir_ret  <= 1'b0;
    end else begin
      if (latch_ir) begin
        ir_call <= is_call;
        ir_ret  <= is_ret;
      end
      if (clr) begin
        stack_q <= '0;
        sp_q    <= '0;
        err_q   <= 1'b0;
      end else begin
        if (push) begin
          stack_q[push_idx] <= pc_q + ADDR_W'(1);
          sp_q              <= sp_q + SP_W'(1);
        end
        if (pop)     sp_q  <= sp_q - SP_W'(1);
        if (set_err) err_q <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch addresses are queued as instructions are issued.
module tb_fetch_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       instr_req, instr_ack = 1'b0, is_jump = 1'b0, is_halt = 1'b0;
  logic [1:0] jump_op = 2'b00;
  logic [7:0] instr_addr, jump_target = 8'h00, pc;
  logic       exec_en, exec_done = 1'b0, status_we = 1'b0, jump_taken, halted;
  logic [2:0] alu_status = 3'b000, status;
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
  logic       is_call = 1'b0, is_ret = 1'b0, stack_err;
  logic       call_nx = 1'b0, ret_nx = 1'b0;
`endif

  int         errors = 0, checks = 0;
  logic [7:0] sb[$];
  logic [2:0] mst = 3'b000;

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
    .is_jump(is_jump), .is_halt(is_halt), .jump_op(jump_op), .jump_target(jump_target),
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
    .is_call(is_call), .is_ret(is_ret), .stack_err(stack_err),
`endif
    .exec_en(exec_en), .exec_done(exec_done), .status_we(status_we), .alu_status(alu_status),
    .status(status), .pc(pc), .jump_taken(jump_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic cond_of(input logic [1:0] op, input logic [2:0] st);
    return (op == 2'b00) || (op == 2'b01 && st[0]) || (op == 2'b10 && st[1]) || (op == 2'b11 && st[2]);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for a fetch request, answers it, and leaves the DUT in DECODE.
  task automatic fetch(input logic j, input logic h, input logic [1:0] op, input logic [7:0] tgt,
                       output logic [7:0] addr, output bit ok);
    int n = 0;
    while (instr_req !== 1'b1 && n < 20) begin step(); n++; end
    ok   = (instr_req === 1'b1);
    addr = instr_addr;
    is_jump = j; is_halt = h; jump_op = op; jump_target = tgt; instr_ack = 1'b1;
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
    is_call = call_nx; is_ret = ret_nx;
`endif
    step();
    is_jump = 1'b0; is_halt = 1'b0; jump_op = 2'b00; jump_target = 8'h00; instr_ack = 1'b0;
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
    is_call = 1'b0; is_ret = 1'b0;
`endif
  endtask

  // From DECODE of a non-jump: holds exec_done low for delay-1 cycles, counts exec_en cycles.
  task automatic execute(input int delay, input logic we, input logic [2:0] st, output int hi);
    step();
    hi = 0;
    for (int k = 0; k < delay; k++) begin
      if (exec_en === 1'b1) hi++;
      if (k == delay - 1) begin exec_done = 1'b1; status_we = we; alu_status = st; end
      step();
    end
    exec_done = 1'b0; status_we = 1'b0; alu_status = 3'b000;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    rst_n = 1'b0;
    #12;
    obs = {instr_req, exec_en, jump_taken, halted, status, pc};
    checks++;
    if (obs !== 15'h0) begin errors++; $display("FAIL reset_state: got %h want 0000", obs); end
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    obs = {instr_req, halted, status, instr_addr, 2'b00};
    checks++;
    if (obs !== {1'b1, 1'b0, 3'b000, 8'h00, 2'b00}) begin
      errors++; $display("FAIL start_fetch: got %h want %h", obs, {1'b1, 1'b0, 3'b000, 8'h00, 2'b00});
    end
    sb.push_back(8'h00);
  endtask

  task automatic test_sequential();
    logic [7:0] a, e; bit ok; int hi;
    for (int i = 0; i < 3; i++) begin
      fetch(1'b0, 1'b0, 2'b00, 8'h00, a, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || a !== e) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, a, e); end
      sb.push_back(e + 8'h01);
      execute(2, 1'b0, 3'b000, hi);
      checks++;
      if (hi != 2 || exec_en !== 1'b0) begin
        errors++; $display("FAIL seq_exec_en%0d: got %0d cycles (now %b) want 2 (now 0)", i, hi, exec_en);
      end
    end
  endtask

  task automatic test_cond_jump();
    logic [7:0] a, e; bit ok; int hi;
    fetch(1'b0, 1'b0, 2'b00, 8'h00, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e) begin errors++; $display("FAIL cj_addr0: got %h want %h", a, e); end
    sb.push_back(e + 8'h01);
    execute(1, 1'b1, 3'b001, hi);
    mst = 3'b001;
    checks++;
    if (status !== mst) begin errors++; $display("FAIL cj_status: got %b want %b", status, mst); end
    // op=01 taken on status[0]
    fetch(1'b1, 1'b0, 2'b01, 8'h40, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e) begin errors++; $display("FAIL cj_addr1: got %h want %h", a, e); end
    sb.push_back(cond_of(2'b01, mst) ? 8'h40 : e + 8'h01);
    step();
    checks++;
    if ({instr_req, jump_taken, instr_addr} !== {1'b1, 1'b1, sb[0]}) begin
      errors++; $display("FAIL cj_latency: got req=%b taken=%b addr=%h want 1 1 %h", instr_req, jump_taken, instr_addr, sb[0]);
    end
    // op=10 not taken; pulse must already be gone
    fetch(1'b1, 1'b0, 2'b10, 8'h80, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e || jump_taken !== 1'b0) begin
      errors++; $display("FAIL cj_addr2: got %h taken=%b want %h taken=0", a, jump_taken, e);
    end
    sb.push_back(cond_of(2'b10, mst) ? 8'h80 : e + 8'h01);
    step();
    checks++;
    if (jump_taken !== 1'b0 || instr_addr !== sb[0]) begin
      errors++; $display("FAIL cj_not_taken: got taken=%b addr=%h want 0 %h", jump_taken, instr_addr, sb[0]);
    end
    fetch(1'b1, 1'b0, 2'b00, 8'h90, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e) begin errors++; $display("FAIL cj_addr3: got %h want %h", a, e); end
    sb.push_back(8'h90);
  endtask

  task automatic test_wrap_halt();
    logic [7:0] a, e; bit ok; int hi;
    fetch(1'b1, 1'b0, 2'b00, 8'hFF, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e) begin errors++; $display("FAIL wr_addr0: got %h want %h", a, e); end
    sb.push_back(8'hFF);
    fetch(1'b0, 1'b0, 2'b00, 8'h00, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e) begin errors++; $display("FAIL wr_addr1: got %h want %h", a, e); end
    sb.push_back(8'h00);
    execute(1, 1'b1, 3'b101, hi);
    mst = 3'b101;
    fetch(1'b1, 1'b0, 2'b11, 8'h10, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e) begin errors++; $display("FAIL wr_wrap: got %h want %h", a, e); end
    sb.push_back(cond_of(2'b11, mst) ? 8'h10 : 8'h01);
    // halt and jump both set: halt must win, pc frozen
    fetch(1'b1, 1'b1, 2'b00, 8'h33, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e) begin errors++; $display("FAIL wr_addr3: got %h want %h", a, e); end
    for (int k = 0; k < 4; k++) step();
    checks++;
    if ({halted, instr_req, pc} !== {1'b1, 1'b0, e}) begin
      errors++; $display("FAIL halt_state: got halted=%b req=%b pc=%h want 1 0 %h", halted, instr_req, pc, e);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({halted, instr_req, instr_addr, status} !== {1'b1 ^ 1'b1, 1'b1, 8'h00, 3'b000}) begin
      errors++; $display("FAIL restart: got halted=%b req=%b addr=%h st=%b want 0 1 00 000", halted, instr_req, instr_addr, status);
    end
    sb.push_back(8'h00);
  endtask

  task automatic test_midop_reset();
    logic [7:0] a, e; bit ok;
    fetch(1'b1, 1'b0, 2'b00, 8'h55, a, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || a !== e) begin errors++; $display("FAIL mr_addr0: got %h want %h", a, e); end
    fetch(1'b0, 1'b0, 2'b00, 8'h00, a, ok);
    checks++;
    if (!ok || a !== 8'h55) begin errors++; $display("FAIL mr_addr1: got %h want 55", a); end
    step();
    checks++;
    if (exec_en !== 1'b1) begin errors++; $display("FAIL mr_exec_en: got %b want 1", exec_en); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({exec_en, instr_req, pc} !== {1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL mr_async: got en=%b req=%b pc=%h want 0 0 00", exec_en, instr_req, pc);
    end
    exec_done = 1'b1;
    #2 rst_n = 1'b1;
    step(); step();
    exec_done = 1'b0;
    checks++;
    if ({exec_en, instr_req, halted, pc} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL mr_idle: got en=%b req=%b halted=%b pc=%h want 0 0 0 00", exec_en, instr_req, halted, pc);
    end
    sb.delete();
  endtask

`ifdef FETCH_SEQUENCER_CALL_STACK_EN
  task automatic test_call_stack();
    logic [7:0] a; bit ok;
    start = 1'b1; step(); start = 1'b0;
    fetch(1'b1, 1'b0, 2'b00, 8'h05, a, ok);
    call_nx = 1'b1;
    fetch(1'b0, 1'b0, 2'b00, 8'h20, a, ok);
    call_nx = 1'b0;
    step();
    checks++;
    if (!ok || a !== 8'h05 || instr_addr !== 8'h20 || jump_taken !== 1'b1) begin
      errors++; $display("FAIL call: got from %h to %h taken=%b want 05 20 1", a, instr_addr, jump_taken);
    end
    ret_nx = 1'b1;
    fetch(1'b0, 1'b0, 2'b00, 8'h00, a, ok);
    ret_nx = 1'b0;
    step();
    checks++;
    if (instr_addr !== 8'h06 || jump_taken !== 1'b1) begin
      errors++; $display("FAIL ret: got %h taken=%b want 06 1", instr_addr, jump_taken);
    end
    call_nx = 1'b1;
    for (int i = 0; i < 5; i++) fetch(1'b0, 1'b0, 2'b00, 8'h30 + 8'(i), a, ok);
    call_nx = 1'b0;
    step();
    checks++;
    if ({stack_err, halted, pc} !== {1'b1, 1'b1, 8'h33}) begin
      errors++; $display("FAIL overflow: got err=%b halted=%b pc=%h want 1 1 33", stack_err, halted, pc);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({stack_err, halted, instr_addr} !== {1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL err_clear: got err=%b halted=%b addr=%h want 0 0 00", stack_err, halted, instr_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_cond_jump();
    test_wrap_halt();
    test_midop_reset();
`ifdef FETCH_SEQUENCER_CALL_STACK_EN
    test_call_stack();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
